// File: rtl/reg_share_arb_if.sv
// rtl/reg_share_arb_if.sv - request/grant and shared-register signal bundle for reg_share_arb
//
// Purpose: groups the requester side (req/lock/data/clr) and the shared register
// side (gnt/reg_en/reg_rst/reg_d/owner/wcount) of the arbiter.
// Ports (signals):
//   req[R], lock[R], data[R*N], clr      requester -> arbiter
//   gnt[R], reg_en, reg_rst, reg_d[N]    arbiter -> requesters / shared register
//   owner[IW], wcount[16]                arbiter status
// Modports: master (requesters / bench), slave (arbiter).
interface reg_share_arb_if #(
  parameter int N  = 64,
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
);
  logic [R-1:0]   req;
  logic [R-1:0]   lock;
  logic [R*N-1:0] data;
  logic           clr;
  logic [R-1:0]   gnt;
  logic           reg_en;
  logic           reg_rst;
  logic [N-1:0]   reg_d;
  logic [IW-1:0]  owner;
  logic [15:0]    wcount;

  modport master (
    output req, lock, data, clr,
    input  gnt, reg_en, reg_rst, reg_d, owner, wcount
  );

  modport slave (
    input  req, lock, data, clr,
    output gnt, reg_en, reg_rst, reg_d, owner, wcount
  );
endinterface

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin write arbiter for a shared enable/reset register
//
// Purpose: lets R requesters take turns writing one N-bit register, with locked
// multi-cycle ownership, a synchronous clear and a saturating write counter.
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    reg_share_arb_if.slave: req/lock/data/clr in; gnt/reg_en/reg_rst/reg_d/owner/wcount out
module reg_share_arb #(
  parameter int N = 64,
  parameter int R = 4
) (
  input logic             clk,
  input logic             reset,
  reg_share_arb_if.slave  bus
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [R-1:0] GNT_ONE = R'(1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, CLEAR} state_t;

  state_t        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic [R-1:0]  gnt_q;
  logic          en_q;
  logic          rst_q;
  logic [N-1:0]  d_q;
  logic [15:0]   wcount_q;

  logic          busy;
  logic          hold_go;
  logic [R-1:0]  elig;
  logic [IW-1:0] cand;
  logic          win_found;
  logic [IW-1:0] win_idx;

  // The owner's req is still high for one cycle after its grant, so it is
  // masked out of arbitration while the owner is writing.
  always_comb begin
    busy      = (state_q == WRITE) || (state_q == HOLD);
    hold_go   = busy && bus.req[owner_q] && bus.lock[owner_q];
    elig      = busy ? (bus.req & ~(GNT_ONE << owner_q)) : bus.req;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    // Search ptr+1, ptr+2, ... wrapping modulo R; the first eligible bit wins.
    for (int k = 1; k <= R; k++) begin
      cand = IW'((int'(ptr_q) + k) % R);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(R - 1);
      owner_q  <= '0;
      gnt_q    <= '0;
      en_q     <= 1'b0;
      rst_q    <= 1'b0;
      d_q      <= '0;
      wcount_q <= '0;
    end else if (bus.clr) begin
      // Abort any write; ptr and owner are left alone, pending reqs stay pending.
      state_q <= CLEAR;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b1;
    end else if (hold_go) begin
      state_q <= HOLD;
      gnt_q   <= '0;
      en_q    <= 1'b1;
      rst_q   <= 1'b0;
      d_q     <= bus.data[owner_q*N +: N];
      if (wcount_q != 16'hFFFF) wcount_q <= wcount_q + 16'd1;
    end else if (win_found) begin
      state_q <= WRITE;
      gnt_q   <= GNT_ONE << win_idx;
      en_q    <= 1'b1;
      rst_q   <= 1'b0;
      d_q     <= bus.data[win_idx*N +: N];
      owner_q <= win_idx;
      ptr_q   <= win_idx;
      if (wcount_q != 16'hFFFF) wcount_q <= wcount_q + 16'd1;
    end else begin
      state_q <= IDLE;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.reg_en  = en_q;
  assign bus.reg_rst = rst_q;
  assign bus.reg_d   = d_q;
  assign bus.owner   = owner_q;
  assign bus.wcount  = wcount_q;
endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - self-checking bench for reg_share_arb
module tb_reg_share_arb;
  localparam int N  = 64;
  localparam int R  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_share_arb_if #(.N(N), .R(R)) bus();

  reg_share_arb #(.N(N), .R(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The shared register being written.
  logic [N-1:0] q = '0;
  always @(posedge clk) begin
    if (reset)            q <= '0;
    else if (bus.reg_rst) q <= '0;
    else if (bus.reg_en)  q <= bus.reg_d;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "active" means the last edge performed a write (grant or hold).
  bit            m_active;
  logic [IW-1:0] m_ptr;
  logic [IW-1:0] m_own;
  logic [R-1:0]  m_gnt;
  bit            m_en;
  bit            m_rst;
  logic [N-1:0]  m_d;
  int            m_cnt;

  task automatic model_edge();
    logic [R-1:0]  elig;
    logic [IW-1:0] idx;
    int            w;
    if (reset) begin
      m_active = 0; m_ptr = IW'(R - 1); m_own = '0;
      m_gnt = '0; m_en = 0; m_rst = 0; m_d = '0; m_cnt = 0;
    end else if (bus.clr) begin
      m_active = 0; m_gnt = '0; m_en = 0; m_rst = 1;
    end else if (m_active && bus.req[m_own] && bus.lock[m_own]) begin
      m_gnt = '0; m_en = 1; m_rst = 0;
      m_d = bus.data[m_own*N +: N];
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      elig = bus.req;
      if (m_active) elig[m_own] = 1'b0;
      w = -1;
      for (int k = 1; k <= R; k++) begin
        idx = IW'((int'(m_ptr) + k) % R);
        if (w < 0 && elig[idx]) w = int'(idx);
      end
      if (w >= 0) begin
        m_active = 1; m_gnt = '0; m_gnt[w] = 1'b1; m_en = 1; m_rst = 0;
        m_d = bus.data[w*N +: N];
        m_own = IW'(w); m_ptr = IW'(w);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_active = 0; m_gnt = '0; m_en = 0; m_rst = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [R-1:0] gnt, input bit en, input bit rst,
                           input logic [N-1:0] d, input int own, input int wc);
    chk({tag, ".gnt"},     64'(bus.gnt),     64'(gnt));
    chk({tag, ".reg_en"},  64'(bus.reg_en),  64'(en));
    chk({tag, ".reg_rst"}, 64'(bus.reg_rst), 64'(rst));
    chk({tag, ".reg_d"},   bus.reg_d,        d);
    chk({tag, ".owner"},   64'(bus.owner),   64'(own));
    chk({tag, ".wcount"},  64'(bus.wcount),  64'(wc));
  endtask

  // Apply inputs, let one active edge pass, sample 1 time unit later.
  task automatic drive(input bit rs, input logic [R-1:0] rq, input logic [R-1:0] lk, input bit c);
    reset = rs; bus.req = rq; bus.lock = lk; bus.clr = c;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [N-1:0] v);
    bus.data[i*N +: N] = v;
  endtask

  typedef struct {
    bit             rs;
    logic [R-1:0]   req;
    logic [R-1:0]   lk;
    bit             clr;
    logic [R*N-1:0] data;
    logic [R-1:0]   gnt;
    bit             en;
    bit             rst;
    logic [N-1:0]   d;
    int             own;
    int             wc;
    logic [N-1:0]   q;
  } vec_t;

  localparam logic [R*N-1:0] D1 = {64'h0, 64'h0, 64'h0, 64'hcafe};
  localparam logic [R*N-1:0] D2 = {64'hcac0, 64'hc4c0, 64'hc3c1, 64'hc0c0};

  vec_t tbl [9];

  initial begin
    bus.req = '0; bus.lock = '0; bus.clr = 1'b0; bus.data = '0;

    // Test 1 and 2: single write, then a four-way round robin after reset.
    tbl[0] = '{1, 4'b0000, 4'b0, 0, D1, 4'b0000, 0, 0, 64'h0,    0, 0, 64'h0};
    tbl[1] = '{0, 4'b0001, 4'b0, 0, D1, 4'b0001, 1, 0, 64'hcafe, 0, 1, 64'h0};
    tbl[2] = '{0, 4'b0000, 4'b0, 0, D1, 4'b0000, 0, 0, 64'hcafe, 0, 1, 64'hcafe};
    tbl[3] = '{1, 4'b0000, 4'b0, 0, D2, 4'b0000, 0, 0, 64'h0,    0, 0, 64'h0};
    tbl[4] = '{0, 4'b1111, 4'b0, 0, D2, 4'b0001, 1, 0, 64'hc0c0, 0, 1, 64'h0};
    tbl[5] = '{0, 4'b1110, 4'b0, 0, D2, 4'b0010, 1, 0, 64'hc3c1, 1, 2, 64'hc0c0};
    tbl[6] = '{0, 4'b1100, 4'b0, 0, D2, 4'b0100, 1, 0, 64'hc4c0, 2, 3, 64'hc3c1};
    tbl[7] = '{0, 4'b1000, 4'b0, 0, D2, 4'b1000, 1, 0, 64'hcac0, 3, 4, 64'hc4c0};
    tbl[8] = '{0, 4'b0000, 4'b0, 0, D2, 4'b0000, 0, 0, 64'hcac0, 3, 4, 64'hcac0};

    for (int i = 0; i < 9; i++) begin
      bus.data = tbl[i].data;
      drive(tbl[i].rs, tbl[i].req, tbl[i].lk, tbl[i].clr);
      check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].en, tbl[i].rst, tbl[i].d, tbl[i].own, tbl[i].wc);
      chk($sformatf("vec%0d.q", i), q, tbl[i].q);
    end

    // Test 3: locked hold by requester 2 while requester 0 waits.
    set_d(1, 64'h1111);
    drive(0, 4'b0010, 4'b0000, 0);
    check_out("t3.g1", 4'b0010, 1, 0, 64'h1111, 1, 5);
    set_d(2, 64'hdad0); set_d(0, 64'h0a0a);
    drive(0, 4'b0101, 4'b0100, 0);
    check_out("t3.g2", 4'b0100, 1, 0, 64'hdad0, 2, 6);
    set_d(2, 64'hcec1);
    drive(0, 4'b0101, 4'b0100, 0);
    check_out("t3.h1", 4'b0000, 1, 0, 64'hcec1, 2, 7);
    drive(0, 4'b0101, 4'b0100, 0);
    check_out("t3.h2", 4'b0000, 1, 0, 64'hcec1, 2, 8);
    drive(0, 4'b0001, 4'b0000, 0);
    check_out("t3.g0", 4'b0001, 1, 0, 64'h0a0a, 0, 9);
    drive(0, 4'b0000, 4'b0000, 0);
    check_out("t3.idle", 4'b0000, 0, 0, 64'h0a0a, 0, 9);

    // Test 4: clear during hold, then clear together with a request.
    set_d(1, 64'hb1b1);
    drive(0, 4'b0010, 4'b0010, 0);
    check_out("t4.g1", 4'b0010, 1, 0, 64'hb1b1, 1, 10);
    drive(0, 4'b0010, 4'b0010, 0);
    check_out("t4.hold", 4'b0000, 1, 0, 64'hb1b1, 1, 11);
    drive(0, 4'b0000, 4'b0000, 1);
    check_out("t4.clr1", 4'b0000, 0, 1, 64'hb1b1, 1, 11);
    chk("t4.q_before", q, 64'hb1b1);
    set_d(1, 64'hb2b2);
    drive(0, 4'b0010, 4'b0000, 1);
    check_out("t4.clr2", 4'b0000, 0, 1, 64'hb1b1, 1, 11);
    chk("t4.q_cleared", q, 64'h0);
    drive(0, 4'b0010, 4'b0000, 0);
    check_out("t4.g1b", 4'b0010, 1, 0, 64'hb2b2, 1, 12);
    drive(0, 4'b0000, 4'b0000, 0);
    check_out("t4.idle", 4'b0000, 0, 0, 64'hb2b2, 1, 12);

    // Test 5: reset in the middle of a write, pointer back to R-1.
    set_d(2, 64'he2e2);
    drive(0, 4'b0100, 4'b0000, 0);
    check_out("t5.g2", 4'b0100, 1, 0, 64'he2e2, 2, 13);
    drive(1, 4'b0100, 4'b0000, 0);
    check_out("t5.rst", 4'b0000, 0, 0, 64'h0, 0, 0);
    set_d(3, 64'hf3f3); set_d(0, 64'hf0f0);
    drive(0, 4'b1000, 4'b0000, 0);
    check_out("t5.g3", 4'b1000, 1, 0, 64'hf3f3, 3, 1);
    drive(0, 4'b0001, 4'b0000, 0);
    check_out("t5.g0", 4'b0001, 1, 0, 64'hf0f0, 0, 2);
    drive(0, 4'b0000, 4'b0000, 0);

    // Randomised traffic against the reference model, including reset mid-hold.
    drive(1, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < R; r++) set_d(r, {$urandom, $urandom});
      drive(($urandom % 60) == 0, R'($urandom), R'($urandom), ($urandom % 12) == 0);
      check_out("rnd", m_gnt, m_en, m_rst, m_d, int'(m_own), m_cnt);
    end

    // Test 6: counter saturation under a continuous locked hold.
    drive(1, 4'b0000, 4'b0000, 0);
    set_d(0, 64'h5a5a);
    for (int i = 1; i <= 65540; i++) begin
      drive(0, 4'b0001, 4'b0001, 0);
      if (i == 65534) chk("t6.wc_fffe", 64'(bus.wcount), 64'hFFFE);
      if (i == 65535) chk("t6.wc_ffff", 64'(bus.wcount), 64'hFFFF);
    end
    set_d(0, 64'ha5a5);
    drive(0, 4'b0001, 4'b0001, 0);
    check_out("t6.sat", 4'b0000, 1, 0, 64'ha5a5, 0, 65535);
    drive(0, 4'b0000, 4'b0000, 0);
    chk("t6.q", q, 64'ha5a5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin write arbiter for a shared N-bit enable/reset register. It lets R requesters take turns writing one register, such as a pipeline or scratch register. The block drives the register's `enable`, `reset` and `d` inputs. It returns a one-cycle grant to the winning requester, supports locked multi-cycle ownership, and counts committed writes.

## Interface
- `N`, 64, data width of the shared register.
- `R`, 4, number of requesters (2..8); `IW = $clog2(R)`.

- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge clk.
- `req`  in  R  level request per requester; held until granted.
- `lock`  in  R  per-requester ownership request; meaningful only with `req`.
- `data`  in  R*N  flattened write data; slice i is `data[i*N +: N]` and must be stable while `req[i]` = 1.
- `clr`  in  1  synchronous clear request for the shared register.
- `gnt`  out  R  registered one-hot grant; 0 when no write this cycle.
- `reg_en`  out  1  enable to the shared register.
- `reg_rst`  out  1  reset to the shared register.
- `reg_d`  out  N  data to the shared register.
- `owner`  out  IW  index of the last granted requester.
- `wcount`  out  16  committed-write counter, saturating.

## Operation
- States: IDLE, WRITE, HOLD, CLEAR.
- All outputs are registered and are a function of the state entered.
- Arbitration is round-robin:
  - Search starts at index `ptr+1 mod R` and wraps.
  - The first eligible `req` bit wins.
  - `ptr` is set to the winner on every grant.
  - `ptr` resets to R-1, so requester 0 wins first.
- Eligible requests:
  - In IDLE and CLEAR: every `req` bit.
  - In WRITE and HOLD: every `req` bit except the current owner's. Its `req` is still high for one cycle after `gnt`.
- Per-edge priority, highest first: `reset`, then `clr`, then the hold condition, then arbitration.
- `reset`:
  - State goes to IDLE; `ptr` = R-1.
  - `gnt`, `reg_en`, `reg_rst`, `reg_d` and `wcount` all become 0; `owner` = 0.
- `clr` = 1:
  - Next state is CLEAR: `reg_rst` = 1, `reg_en` = 0, `gnt` = 0.
  - Any WRITE or HOLD is aborted; `ptr` and `owner` are unchanged.
  - Pending requests stay pending.
- Hold condition: state is WRITE or HOLD, and `req[owner]` and `lock[owner]` are both 1.
  - Next state is HOLD: `reg_en` = 1, `reg_d` = `data[owner]` sampled at this edge, `gnt` = 0.
  - `wcount` increments each HOLD cycle.
- Arbitration with a winner w:
  - Next state is WRITE: `gnt` = one-hot(w), `reg_en` = 1, `reg_d` = `data[w]` sampled at this edge.
  - `owner` = w; `wcount` increments.
- Otherwise the next state is IDLE with `reg_en`, `reg_rst` and `gnt` all 0.
- `reg_d` holds its last value whenever `reg_en` = 0.
- `wcount` saturates at 16'hFFFF and never wraps.
- Requester contract:
  - Keep `req` high until `gnt` is seen, then drop it on the following edge.
  - To keep ownership, hold `req` and `lock` high. HOLD ends on the first edge where either is 0.
- `reg_rst` and `reg_en` are never 1 in the same cycle.

## Timing
- Latency: a `req` sampled at edge E gives `gnt`, `reg_en` and `reg_d` during cycle E..E+1. The shared register's `q` shows the data after edge E+1.
- Throughput: one write per cycle across different requesters, back-to-back WRITEs with no idle gap. A single requester without `lock` gets at most one write per 2 cycles.
- `clr` at edge E gives `reg_rst` during cycle E..E+1; `q` = 0 after E+1.
- `clr` and `req` at the same edge: CLEAR wins and the request is granted at the next edge.
- Reset mid-HOLD: ownership is dropped and nothing is written in the following cycle.

## Test plan
1. Reset, then `req` = 4'b0001 with `data[0]` = 64'hcafe. Required: `gnt` = 0001 and `reg_en` = 1 one cycle later; `q` = 64'hcafe after the next edge; `wcount` = 1.
2. `req` = 4'b1111 held with distinct data 64'hc0c0, 64'hc3c1, 64'hc4c0, 64'hcac0, each requester dropping `req` after its `gnt`. Required: grant order 0, 1, 2, 3 on consecutive cycles; `wcount` = 4; `owner` = 3.
3. Requester 2 holds `req` and `lock` for 3 cycles while `req[0]` = 1, with `data[2]` changing 64'hdad0 to 64'hcec1. Required: HOLD lasts until `lock` drops; `reg_d` follows `data[2]` one edge later; `gnt` = 0100 only on the first cycle; requester 0 is granted right after.
4. `clr` during HOLD, then `clr` together with `req[1]`. Required: `reg_rst` = 1 and `reg_en` = 0 for one cycle; `q` = 0; `req[1]` is granted on the edge after CLEAR; `ptr` is unchanged by `clr`.
5. `reset` asserted mid-WRITE. Required: all outputs 0 next cycle; `ptr` = R-1, so `req` = 4'b1000 followed by 4'b0001 grants 3 first and then 0.
6. Force `wcount` near its limit with 65540 single writes. Required: `wcount` stays at 16'hFFFF and writes still occur.
